otter_io_timer: RTL
===================

# otter_io_timer

Memory-mapped down-counting timer peripheral on the OTTER IOBUS, the responder to the MCU's IOBUS master port. It decodes `IOBUS_ADDR`, accepts register writes on `IOBUS_WR`, returns read data on `IOBUS_IN`, and drives the MCU's `INTR` input when a count expires. One instance sits in the top-level IO wrapper beside the switch, LED and seven-segment logic.

## Interface
- `BASE_ADDR`, default 32'h1100_0100: word-aligned base of the 4-word register window.
- `CLK`  in  1: system clock, shared with the MCU.
- `RST`  in  1: reset, asynchronous, active-high.
- `IOBUS_ADDR`  in  32: MCU IO address.
- `IOBUS_OUT`  in  32: MCU write data.
- `IOBUS_WR`  in  1: write strobe, 1-cycle qualified write.
- `IOBUS_IN`  out  32: read data to the MCU, combinational.
- `INTR`  out  1: interrupt request to the MCU, level.

## Operation
- Register map, offsets from `BASE_ADDR`:
  - 0x0 CSR. bit0 EN; bit1 AR (auto-reload); bit2 IE; bit8 PEND. PEND is read-only and write-1-to-clear. Other bits read 0.
  - 0x4 PRESC, bits[7:0]. A tick occurs every PRESC+1 clocks.
  - 0x8 RELOAD, 32 bits.
  - 0xC COUNT, 32 bits. Reads return the live count; writes load the count.
- An access hits only when `IOBUS_ADDR[31:4] == BASE_ADDR[31:4]` and `IOBUS_ADDR[1:0] == 0`. On a miss, `IOBUS_IN` = 0 and writes are ignored.
- Control FSM has two states, IDLE and RUN. It is in RUN exactly when EN=1.
  - IDLE→RUN: CSR write with EN=1. The prescaler counter clears to 0.
  - RUN→IDLE: CSR write with EN=0, or a one-shot expiry (AR=0).
- Prescaler (RUN only):
  - `pcnt` increments each clock.
  - When `pcnt >= PRESC`, a tick is issued and `pcnt` returns to 0.
  - `pcnt` holds at 0 in IDLE.
- On each tick:
  - COUNT≠0: COUNT ← COUNT−1.
  - COUNT=0 (expiry): PEND ← 1. If AR=1, COUNT ← RELOAD. If AR=0, EN ← 0 and COUNT stays 0.
- Auto-reload period = (RELOAD+1)·(PRESC+1) clocks.
- `INTR` = PEND & IE.

## Timing
- Reset values: all registers, `pcnt` and FSM (IDLE) are 0. `INTR`=0. `IOBUS_IN` reads 0 for every address.
- Writes commit on the rising edge where `IOBUS_WR`=1 and the address hits. The new value is visible on `IOBUS_IN` the following cycle.
- Reads have zero latency: `IOBUS_IN` is a function of `IOBUS_ADDR` and current register state only.
- A CSR write with EN=1 at edge N makes the first tick occur at edge N+PRESC+1.
- `INTR` rises the cycle after the expiry edge, registered from PEND.
- Simultaneous events:
  - COUNT write and tick in the same cycle: the write wins and `pcnt` ← 0.
  - PEND write-1-clear and expiry in the same cycle: the set wins, so PEND stays 1.
  - CSR write with EN=0 and expiry in the same cycle: the write wins for EN. PEND still sets, and AR reload is suppressed.
  - PRESC written while running: takes effect immediately. If the new value is ≤ `pcnt`, a tick fires on the next clock.
- Wrap-around: COUNT never decrements below 0. RELOAD=0 with AR=1 expires on every tick.
- `RST` asserted mid-count returns the block to the reset state asynchronously, including dropping `INTR`.

## Structure
- Package `otter_io_pkg` holds:
  - register offset constants `TMR_CSR`, `TMR_PRESC`, `TMR_RELOAD`, `TMR_COUNT`;
  - CSR bit index constants `CSR_EN`, `CSR_AR`, `CSR_IE`, `CSR_PEND`;
  - the FSM state enum `tmr_state_t` {IDLE, RUN}.
- One sub-module, `otter_io_prescaler`. Inputs: `CLK`, `RST`, run, clear, 8-bit divide value. Output: single-cycle `tick`.
- The top level holds the address decode, register file, count datapath, FSM and read mux.

## Test plan
- Reset: assert `RST` at any time. Expect `INTR`=0 and all four register reads return 0. Accesses outside the window, e.g. `BASE_ADDR`+0x10, return 0 and writes there are ignored.
- One-shot:
  - Stimulus: PRESC=3, COUNT=2, CSR=0x5 (EN, IE).
  - Expect `INTR` to rise 12 clocks after the CSR write edge, and CSR to read 0x104 (EN cleared, PEND set).
  - Writing 0x100 to CSR drops `INTR` next cycle.
- Auto-reload:
  - Stimulus: PRESC=0, RELOAD=4, COUNT=4, CSR=0x7.
  - Expect PEND to set every 5 clocks; clear it after each event.
  - Stop via CSR=0. COUNT then freezes and reads back stable.
- Collision: issue the PEND write-1-clear on the exact expiry cycle. Expect PEND to remain 1 and `INTR` to stay high.
- Collision: write COUNT=0x10 on a tick cycle. Expect a read of 0x10 the next cycle, and the next decrement PRESC+1 clocks later.
- Mid-run reset: assert `RST` while COUNT=7 and running. Expect COUNT=0, EN=0 and `INTR`=0 immediately. After release, no tick occurs until EN is rewritten.

Source files
------------

// File: rtl/otter_io_pkg.sv
// Shared constants, state type and small helpers for the OTTER IOBUS timer.
// Imported by the prescaler and the timer top level.
package otter_io_pkg;

    // Register offsets within the 16-byte window
    localparam logic [3:0] TMR_CSR    = 4'h0;
    localparam logic [3:0] TMR_PRESC  = 4'h4;
    localparam logic [3:0] TMR_RELOAD = 4'h8;
    localparam logic [3:0] TMR_COUNT  = 4'hC;

    localparam int CSR_EN   = 0;
    localparam int CSR_AR   = 1;
    localparam int CSR_IE   = 2;
    localparam int CSR_PEND = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tmr_state_t;

    // The window is 16 bytes; only word-aligned accesses decode.
    function automatic logic windowHit(input logic [27:0] addrHi,
                                       input logic [1:0]  addrLo,
                                       input logic [27:0] baseHi);
        return (addrHi == baseHi) && (addrLo == 2'b00);
    endfunction

    function automatic logic [31:0] csrImage(input logic en,
                                             input logic ar,
                                             input logic ie,
                                             input logic pend);
        logic [31:0] v;
        v           = '0;
        v[CSR_EN]   = en;
        v[CSR_AR]   = ar;
        v[CSR_IE]   = ie;
        v[CSR_PEND] = pend;
        return v;
    endfunction

endpackage

// File: rtl/otter_io_prescaler.sv
// Clock divider for the IO timer: emits a one-cycle tick every div+1 clocks
// while run is high, and sits at zero otherwise.
module otter_io_prescaler
    import otter_io_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       run,
    input  logic       clear,
    input  logic [7:0] div,
    output logic       tick
);

    logic [7:0] pcnt;

    // Comparing with >= lets a smaller divide value written mid-period
    // fire on the very next clock instead of waiting for a wrap.
    assign tick = run && (pcnt >= div);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pcnt <= '0;
        end else if (!run || clear || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 8'd1;
        end
    end

endmodule

// File: rtl/otter_io_timer.sv
// Memory-mapped down-counting timer on the OTTER IOBUS: CSR, prescaler,
// reload and live count registers, with a level interrupt on expiry.
module otter_io_timer
    import otter_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0100
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        INTR
);

    tmr_state_t  state;
    tmr_state_t  stateNext;

    logic        hit;
    logic        wrHit;
    logic        csrWr;
    logic        prescWr;
    logic        reloadWr;
    logic        countWr;

    logic        ar;
    logic        ie;
    logic        pend;
    logic [7:0]  presc;
    logic [31:0] reload;
    logic [31:0] count;

    logic        running;
    logic        startWrite;
    logic        stopWrite;
    logic        tick;
    logic        expiry;
    logic        doReload;
    logic        prescClear;

    assign hit      = windowHit(IOBUS_ADDR[31:4], IOBUS_ADDR[1:0], BASE_ADDR[31:4]);
    assign wrHit    = IOBUS_WR && hit;
    assign csrWr    = wrHit && (IOBUS_ADDR[3:0] == TMR_CSR);
    assign prescWr  = wrHit && (IOBUS_ADDR[3:0] == TMR_PRESC);
    assign reloadWr = wrHit && (IOBUS_ADDR[3:0] == TMR_RELOAD);
    assign countWr  = wrHit && (IOBUS_ADDR[3:0] == TMR_COUNT);

    assign startWrite = csrWr && IOBUS_OUT[CSR_EN];
    assign stopWrite  = csrWr && !IOBUS_OUT[CSR_EN];

    // A COUNT write overrides a coincident tick, so that tick cannot expire.
    assign expiry   = tick && (count == 32'd0) && !countWr;
    assign doReload = expiry && ar && !stopWrite;

    assign prescClear = countWr || (startWrite && (state == IDLE));

    otter_io_prescaler u_prescaler (
        .CLK   (CLK),
        .RST   (RST),
        .run   (running),
        .clear (prescClear),
        .div   (presc),
        .tick  (tick)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // An explicit CSR write decides EN even when a one-shot expiry coincides.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (startWrite) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (stopWrite) begin
                    stateNext = IDLE;
                end else if (!startWrite && expiry && !ar) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        running = (state == RUN);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ar     <= 1'b0;
            ie     <= 1'b0;
            presc  <= '0;
            reload <= '0;
        end else begin
            if (csrWr) begin
                ar <= IOBUS_OUT[CSR_AR];
                ie <= IOBUS_OUT[CSR_IE];
            end
            if (prescWr) begin
                presc <= IOBUS_OUT[7:0];
            end
            if (reloadWr) begin
                reload <= IOBUS_OUT;
            end
        end
    end

    // Expiry outranks a write-1-to-clear so no event is ever lost.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend <= 1'b0;
        end else if (expiry) begin
            pend <= 1'b1;
        end else if (csrWr && IOBUS_OUT[CSR_PEND]) begin
            pend <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (countWr) begin
            count <= IOBUS_OUT;
        end else if (tick) begin
            if (count != 32'd0) begin
                count <= count - 32'd1;
            end else if (doReload) begin
                count <= reload;
            end
        end
    end

    assign INTR = pend && ie;

    always_comb begin
        IOBUS_IN = '0;
        if (hit) begin
            case (IOBUS_ADDR[3:0])
                TMR_CSR:    IOBUS_IN = csrImage(running, ar, ie, pend);
                TMR_PRESC:  IOBUS_IN = {24'd0, presc};
                TMR_RELOAD: IOBUS_IN = reload;
                TMR_COUNT:  IOBUS_IN = count;
                default:    IOBUS_IN = '0;
            endcase
        end
    end

endmodule
